// File: rtl/mem_load_pkg.sv
// Shared types and constants for the memory load sequencer.
package mem_load_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] lane, input size_t size);
    case (size)
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      SIZE_RSVD: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_lane_select.sv
// Little-endian byte/halfword lane selection with zero extension.
module load_lane_select
  import mem_load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  output logic [7:0]  byte_sel,
  output logic [31:0] load_sel
);

  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase

    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (size)
      SIZE_BYTE: load_sel = {24'h000000, byte_sel};
      SIZE_HALF: load_sel = {16'h0000, half_sel};
      default:   load_sel = word;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Multi-cycle memory load sequencer (IDLE/WAIT/CAPTURE/DONE).
// Optional alignment checking is enabled by defining LOAD_ALIGN_CHECK_EN.
module mem_load_unit
  import mem_load_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] mdr,
  output logic [7:0]  byte_out,
  output logic [31:0] load_data
`ifdef LOAD_ALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q;
  size_t             size_q;
  logic [7:0]        byte_sel;
  logic [31:0]       load_sel;
  logic              mis_req;

`ifdef LOAD_ALIGN_CHECK_EN
  assign mis_req = is_misaligned(addr[1:0], size_t'(size));
`else
  assign mis_req = 1'b0;
`endif

  assign mem_addr = {addr_q[31:2], 2'b00};

  // Selection runs on the live memory word so the registered results line up with mdr.
  load_lane_select u_lane_select (
    .word     (mem_data),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .byte_sel (byte_sel),
    .load_sel (load_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      size_q    <= SIZE_WORD;
      mdr       <= '0;
      byte_out  <= '0;
      load_data <= '0;
`ifdef LOAD_ALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        addr_q <= addr;
        size_q <= size_t'(size);
`ifdef LOAD_ALIGN_CHECK_EN
        misaligned <= mis_req;
`endif
      end
      if (state == WAIT) cnt <= cnt + 1'b1;
      else               cnt <= '0;
      if (state == CAPTURE) begin
        mdr       <= mem_data;
        byte_out  <= byte_sel;
        load_data <= load_sel;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = mis_req ? DONE : WAIT;
      end
      WAIT: begin
        mem_rd = 1'b1;
        if (cnt == CNT_LAST) state_next = CAPTURE;
      end
      CAPTURE: begin
        mem_rd     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
